npcnn_pool: RTL and testbench
=============================

NPCNN_POOL -- requirements
Module: npcnn_pool

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset as in the rest of the codebase.
REQ-002 Parameter OS, default 4: side length of the convolution output map consumed; SHALL be even and >= 2.
REQ-003 Parameter DW, default 20: sample width, matching the npcnn out port.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 go  input  1  frame start strobe, sampled in IDLE only.
REQ-007 in_data  input  DW  signed two's-complement conv result, row-major order.
REQ-008 in_valid  input  1  one-cycle qualifier, one per in_data sample; gaps allowed.
REQ-009 out_data  output  DW  signed pooled result, registered.
REQ-010 out_valid  output  1  one-cycle qualifier for out_data.
REQ-011 busy  output  1  high in RUN and DONE states.
REQ-012 done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 The block SHALL perform non-overlapping 2x2 max pooling (stride 2) on an OS x OS map, producing (OS/2)^2 results in row-major order.
REQ-014 States: IDLE -> RUN on go; RUN -> DONE after the OS*OS-th accepted sample; DONE -> IDLE unconditionally after one cycle.
REQ-015 On the IDLE -> RUN transition, the row counter, column counter and output count SHALL clear to 0.
REQ-016 in_valid SHALL be ignored in IDLE and DONE; go SHALL be ignored in RUN and DONE.
REQ-017 Column counter: 0..OS-1, advancing per accepted sample and wrapping to 0 with row increment.
REQ-018 Even rows: at an even column, hold the sample in a pair register; at an odd column, write max(pair, sample) into line buffer entry col/2.
REQ-019 The line buffer SHALL have OS/2 entries of DW bits.
REQ-020 Odd rows at odd columns: compute max(buffer[col/2], pair, sample) and register it to out_data, with out_valid high in the next cycle (latency 1).
REQ-021 All max comparisons SHALL be signed; ties select either value (identical result).
REQ-022 out_data SHALL hold its last value when out_valid is low.
REQ-023 done SHALL pulse in the DONE state, i.e. the cycle after the final sample is accepted, coincident with the final out_valid.
REQ-024 No back-pressure: every result SHALL be presented exactly once.

Reset
REQ-025 While reset is low: state=IDLE, out_data=0, out_valid=0, busy=0, done=0, counters=0, pair register=0, line buffer=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; no further out_valid until a new go is accepted.

Configuration
REQ-027 Macro NPCNN_POOL_RELU_EN: when defined, each accepted sample SHALL be clamped to 0 if negative before pooling (ReLU then pool); when undefined, raw signed samples are pooled and negative results pass through.

Verification
REQ-028 Reset: hold reset low 2 cycles -> all outputs 0, busy=0.
REQ-029 OS=4, go, then samples 1..16 on consecutive cycles -> out_data 6, 8, 14, 16 with one out_valid each; done pulses with the final out_valid; busy falls the cycle after.
REQ-030 OS=4, sixteen samples of -20: with NPCNN_POOL_RELU_EN -> four results of 0; without it -> four results of 0xFFFEC (-20).
REQ-031 Samples 1..16 with in_valid high every third cycle -> results 6, 8, 14, 16, each appearing one cycle after the 6th, 8th, 14th and 16th samples.
REQ-032 Reset low after 9 samples, then go and samples 1..16 -> no output before the restart; after it, 6, 8, 14, 16.
REQ-033 in_valid pulses before go, and a second go during RUN -> ignored; results unchanged at 6, 8, 14, 16.

Source files
------------

// File: rtl/npcnn_pool.sv
// 2x2 stride-2 signed max pooling over an OS x OS row-major stream.
// Define NPCNN_POOL_RELU_EN to clamp negative samples to zero before pooling.
module npcnn_pool #(
  parameter int unsigned OS = 4,
  parameter int unsigned DW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  localparam int unsigned HW = OS / 2;
  localparam int unsigned CW = (OS > 1) ? $clog2(OS) : 1;
  localparam int unsigned IW = (HW > 1) ? $clog2(HW) : 1;
  localparam int unsigned NW = $clog2(HW * HW + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         row_q, row_d, col_q, col_d;
  logic [NW-1:0]         cnt_q, cnt_d;
  logic signed [DW-1:0]  pair_q, pair_d;
  logic signed [DW-1:0]  lbuf_q [HW];
  logic signed [DW-1:0]  lbuf_d [HW];
  logic [DW-1:0]         out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  logic                  accept, last;
  logic signed [DW-1:0]  sample, pmax, wmax;
  logic [IW-1:0]         idx;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

`ifdef NPCNN_POOL_RELU_EN
  assign sample = in_data[DW-1] ? '0 : in_data;
`else
  assign sample = in_data;
`endif

  assign accept = (state_q == StRun) && in_valid;
  assign last   = (row_q == CW'(OS - 1)) && (col_q == CW'(OS - 1));
  assign idx    = IW'(col_q >> 1);
  assign pmax   = smax(pair_q, sample);
  assign wmax   = smax(lbuf_q[idx], pmax);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    pair_d      = pair_q;
    lbuf_d      = lbuf_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (col_q == CW'(OS - 1)) begin
            col_d = '0;
            row_d = last ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          // Even column opens a window; odd column closes its horizontal pair.
          if (!col_q[0]) begin
            pair_d = sample;
          end else if (!row_q[0]) begin
            lbuf_d[idx] = pmax;
          end else begin
            out_data_d  = wmax;
            out_valid_d = 1'b1;
            cnt_d       = cnt_q + 1'b1;
          end
          if (last) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      pair_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < HW; i++) lbuf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      pair_q      <= pair_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      lbuf_q      <= lbuf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_npcnn_pool.sv
// Scoreboard bench for npcnn_pool: a window-max model queues expected results,
// a negedge monitor compares value, timing and the done pulse.
module tb_npcnn_pool;
  localparam int OS = 4;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  npcnn_pool #(.OS(OS), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    int            cyc;
    bit            last;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   frame [OS*OS];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int act(input int v);
`ifdef NPCNN_POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: every out_valid must match the head of the queue, in the predicted cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got %0h expected no output", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data !== e.val || cyc != e.cyc || done !== e.last) begin
            fails++;
            $display("FAIL result: got %0h at cyc %0d done %0b expected %0h at cyc %0d done %0b",
                     out_data, cyc, done, e.val, e.cyc, e.last);
          end
        end
      end else if (done) begin
        tests++;
        fails++;
        $display("FAIL done_alone: got done=1 without out_valid expected done with final result");
      end
    end
  end

  task automatic start();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic send(input int idx, input int v, input int gap);
    int r, c, m, b;
    exp_t e;
    frame[idx] = v;
    r = idx / OS;
    c = idx % OS;
    if (r % 2 == 1 && c % 2 == 1) begin
      b = (r - 1) * OS + (c - 1);
      m = max2(max2(act(frame[b]), act(frame[b+1])),
               max2(act(frame[b+OS]), act(frame[b+OS+1])));
      e.val  = DW'(m);
      e.cyc  = cyc + 1;
      e.last = (idx == OS * OS - 1);
      exp_q.push_back(e);
    end
    in_data  = DW'(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // mode: 0 ramp 1..N, 1 all -20, 2 full-range random, 3 small random (ties, negatives)
  // gmode: 0 back-to-back, 1 every third cycle, 2 random gaps
  task automatic run_frame(input int mode, input int gmode, input bit hold_go);
    int v, g;
    for (int i = 0; i < OS * OS; i++) begin
      case (mode)
        0:       v = i + 1;
        1:       v = -20;
        2:       v = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        default: v = int'($urandom_range(0, 8)) - 4;
      endcase
      case (gmode)
        0:       g = 0;
        1:       g = 2;
        default: g = int'($urandom_range(0, 3));
      endcase
      if (i == OS * OS - 1) g = 0;
      go = hold_go && (i < 4);
      send(i, v, g);
    end
    go = 1'b0;
    check("busy_in_done", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    check("busy_after_done", {31'b0, busy}, 32'd0);
    check("done_after_done", {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    go       = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_data", {12'b0, out_data}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    start();
    run_frame(0, 0, 1'b0);
    start();
    run_frame(1, 0, 1'b0);
    start();
    run_frame(0, 1, 1'b0);

    // Abandon a frame mid-way.
    start();
    for (int i = 0; i < 9; i++) send(i, i + 1, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_out_data", {12'b0, out_data}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("idle_after_rst", {31'b0, busy}, 32'd0);

    // Stray in_valid in IDLE must not start or disturb anything.
    repeat (5) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("idle_stray_busy", {31'b0, busy}, 32'd0);
    start();
    run_frame(0, 0, 1'b1);

    for (int f = 0; f < 20; f++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      start();
      run_frame(2 + (f % 2), 2, f % 3 == 0);
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
